// File: rtl/pokey_serout_pkg.sv
// Shared definitions for the POKEY serial transmitter: frame state encodings.
package pokey_serout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } txState_t;

endpackage

// File: rtl/pokey_tx_shifter.sv
// Transmit shift register: parallel load from the holding register, LSB-first shift-out.
module pokey_tx_shifter #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] loadData,
  output logic                 lsb
);

  logic [DATA_BITS-1:0] shReg;

  always_ff @(posedge clk) begin
    if (load)
      shReg <= loadData;
    else if (shift)
      shReg <= {1'b0, shReg[DATA_BITS-1:1]};
  end

  assign lsb = shReg[0];

endmodule

// File: rtl/pokey_serout.sv
// POKEY SEROUT transmitter: holding register, frame FSM (start, data LSB-first, stop)
// advanced by bit_tick, with SEROR/SEROC style status and force-break gating.
module pokey_serout
  import pokey_serout_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 bit_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 break_en,
  output logic                 sout,
  output logic                 busy,
  output logic                 out_needed,
  output logic                 tx_done,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS);

  txState_t             state;
  logic [DATA_BITS-1:0] holdReg;
  logic                 holdFull;
  logic                 line;
  logic [CNT_W-1:0]     cnt;
  logic                 frameEnd;
  logic                 transfer;
  logic                 shShift;
  logic                 shLsb;

  // A new frame may start from IDLE or straight out of the last stop bit.
  assign frameEnd = (state == ST_IDLE) || ((state == ST_STOP) && (cnt >= STOP_LAST));
  assign transfer = bit_tick && holdFull && frameEnd;
  assign shShift  = bit_tick && ((state == ST_START) ||
                                 ((state == ST_DATA) && (cnt < DATA_LAST)));

  pokey_tx_shifter #(.DATA_BITS(DATA_BITS)) shifter (
    .clk      (clk),
    .load     (transfer),
    .shift    (shShift),
    .loadData (holdReg),
    .lsb      (shLsb)
  );

  always_ff @(posedge clk) begin
    if (wr_en)
      holdReg <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state      <= ST_IDLE;
      holdFull   <= 1'b0;
      line       <= 1'b1;
      cnt        <= '0;
      out_needed <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b1;
    end else begin
      out_needed <= transfer;
      overrun    <= wr_en && holdFull && !transfer;
      busy       <= (state != ST_IDLE);
      tx_done    <= (state == ST_IDLE) && !holdFull;

      // A write coinciding with a transfer refills the register the shifter just emptied.
      if (wr_en)
        holdFull <= 1'b1;
      else if (transfer)
        holdFull <= 1'b0;

      if (transfer) begin
        line  <= 1'b0;
        state <= ST_START;
      end else if (bit_tick) begin
        case (state)
          ST_IDLE:  line <= 1'b1;
          ST_START: begin
            line  <= shLsb;
            cnt   <= CNT_ONE;
            state <= ST_DATA;
          end
          ST_DATA: begin
            if (cnt < DATA_LAST) begin
              line <= shLsb;
              cnt  <= cnt + CNT_ONE;
            end else begin
              line  <= 1'b1;
              cnt   <= CNT_ONE;
              state <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (cnt < STOP_LAST)
              cnt <= cnt + CNT_ONE;
            else
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sout = line & ~break_en;

endmodule

// File: tb/tb_pokey_serout.sv
// Bench for pokey_serout: two configurations (8N1, 5N2) driven in parallel and checked
// every cycle against a frame-vector model, plus literal frame expectations.
module tb_pokey_serout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       R = 1'b1, tick = 1'b0, wr = 1'b0, brk = 1'b0;
  logic [7:0] data = 8'h00;
  logic soutA, busyA, needA, doneA, ovrA;
  logic soutB, busyB, needB, doneB, ovrB;

  pokey_serout #(.DATA_BITS(8), .STOP_BITS(1)) dutA (
    .clk(clk), .R(R), .bit_tick(tick), .wr_en(wr), .wr_data(data), .break_en(brk),
    .sout(soutA), .busy(busyA), .out_needed(needA), .tx_done(doneA), .overrun(ovrA));

  pokey_serout #(.DATA_BITS(5), .STOP_BITS(2)) dutB (
    .clk(clk), .R(R), .bit_tick(tick), .wr_en(wr), .wr_data(data[4:0]), .break_en(brk),
    .sout(soutB), .busy(busyB), .out_needed(needB), .tx_done(doneB), .overrun(ovrB));

  int nCmp = 0, nBad = 0;
  int needCntA = 0, ovrCntA = 0;

  // Model: a frame is a bit vector {stops, data, start}; mPos walks it one bit per tick.
  int         mD[2] = '{8, 5};
  int         mS[2] = '{1, 2};
  int         mPos[2];
  logic [15:0] mFrame[2];
  logic [7:0] mHold[2];
  logic       mHF[2], mLine[2], mBusy[2], mDone[2], mNeed[2], mOvr[2];

  task automatic check(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      logic inF, hf, xfer;
      int len;
      logic [7:0] dm;
      len = 1 + mD[k] + mS[k];
      dm  = (k == 0) ? data : {3'b000, data[4:0]};
      if (R) begin
        mPos[k] = 0; mHF[k] = 1'b0; mLine[k] = 1'b1; mBusy[k] = 1'b0;
        mDone[k] = 1'b1; mNeed[k] = 1'b0; mOvr[k] = 1'b0;
      end else begin
        inF = (mPos[k] != 0);
        hf = mHF[k];
        xfer = 1'b0;
        if (tick) begin
          if (mPos[k] != 0 && mPos[k] < len) begin
            mLine[k] = mFrame[k][mPos[k]];
            mPos[k]++;
          end else if (hf) begin
            mFrame[k] = (((16'd1 << mS[k]) - 16'd1) << (mD[k] + 1)) | (16'(mHold[k]) << 1);
            mLine[k] = 1'b0;
            mPos[k] = 1;
            xfer = 1'b1;
          end else begin
            mPos[k] = 0;
            mLine[k] = 1'b1;
          end
        end
        mNeed[k] = xfer;
        mOvr[k]  = wr && hf && !xfer;
        if (wr) begin
          mHold[k] = dm;
          mHF[k] = 1'b1;
        end else if (xfer) begin
          mHF[k] = 1'b0;
        end
        mBusy[k] = inF;
        mDone[k] = !inF && !hf;
      end
    end
  endtask

  task automatic compareAll();
    check("A.sout", soutA, mLine[0] & ~brk);
    check("A.busy", busyA, mBusy[0]);
    check("A.out_needed", needA, mNeed[0]);
    check("A.tx_done", doneA, mDone[0]);
    check("A.overrun", ovrA, mOvr[0]);
    check("B.sout", soutB, mLine[1] & ~brk);
    check("B.busy", busyB, mBusy[1]);
    check("B.out_needed", needB, mNeed[1]);
    check("B.tx_done", doneB, mDone[1]);
    check("B.overrun", ovrB, mOvr[1]);
  endtask

  task automatic step(input logic t, input logic w, input logic [7:0] d);
    tick = t; wr = w; data = d;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareAll();
    if (needA) needCntA++;
    if (ovrA) ovrCntA++;
    tick = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic tickAfter(input int gap);
    idle(gap - 1);
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    R = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    R = 1'b0;
  endtask

  logic exp1[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
  logic exp3[10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
  logic exp6[8]  = '{0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    // Reset state and 8'hA5 frame at one tick per 16 clk
    doReset();
    check("rst.sout", soutA, 1'b1);
    check("rst.busy", busyA, 1'b0);
    check("rst.tx_done", doneA, 1'b1);
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 11; i++) begin
      tickAfter(16);
      check("t1.sout", soutA, exp1[i]);
      if (i == 0) check("t1.out_needed", needA, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00);
    check("t1.tx_done", doneA, 1'b1);

    // Back-to-back frames: second byte written during the first start bit
    doReset();
    needCntA = 0; ovrCntA = 0;
    step(1'b0, 1'b1, 8'h0F);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h3C);
    for (int i = 2; i <= 22; i++) begin
      tickAfter(4);
      if (i == 11) begin
        check("t2.start2.sout", soutA, 1'b0);
        check("t2.start2.out_needed", needA, 1'b1);
      end
    end
    checkInt("t2.out_needed_count", needCntA, 2);
    checkInt("t2.overrun_count", ovrCntA, 0);

    // Overwrite before any tick: overrun, only the second byte is sent
    doReset();
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    check("t3.overrun", ovrA, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tickAfter(3);
      check("t3.sout", soutA, exp3[i]);
    end

    // Reset in the 4th data bit aborts the frame
    doReset();
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 5; i++) tickAfter(3);
    R = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    R = 1'b0;
    check("t4.sout", soutA, 1'b1);
    check("t4.busy", busyA, 1'b0);
    check("t4.tx_done", doneA, 1'b1);
    for (int i = 0; i < 3; i++) tickAfter(3);
    check("t4.after.sout", soutA, 1'b1);
    check("t4.after.busy", busyA, 1'b0);

    // Force-break mid-frame on 8'hFF
    doReset();
    step(1'b0, 1'b1, 8'hFF);
    tickAfter(3);
    tickAfter(3);
    brk = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      tickAfter(3);
      check("t5.break.sout", soutA, 1'b0);
    end
    brk = 1'b0;
    for (int i = 7; i <= 11; i++) begin
      tickAfter(3);
      check("t5.release.sout", soutA, 1'b1);
    end

    // 5 data + 2 stop: 8-tick frame; write on the final stop tick transfers a tick later
    doReset();
    step(1'b0, 1'b1, 8'h1B);
    for (int i = 0; i < 7; i++) begin
      tickAfter(3);
      check("t6.sout", soutB, exp6[i]);
    end
    idle(2);
    step(1'b1, 1'b1, 8'h0A);
    check("t6.stop2.sout", soutB, exp6[7]);
    check("t6.stop2.out_needed", needB, 1'b0);
    tickAfter(3);
    check("t6.next.sout", soutB, 1'b0);
    check("t6.next.out_needed", needB, 1'b1);
    idle(40);

    // Randomized traffic
    doReset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) brk = ~brk;
      R = ($urandom_range(0, 599) == 0);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), 8'($urandom));
    end
    R = 1'b0; brk = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
